// File: rtl/display_pkg.sv
// Shared types and constants for the frame-synchronised digit loader.
//   state_e       : loader FSM states
//   bcd_nibble_t  : one BCD digit
//   NIBBLE_W      : bits per BCD digit
//   DIGIT_MAX     : largest displayable value for the default 4-digit display
//   pow10()       : constant helper, 10**n
package display_pkg;

   localparam int NIBBLE_W   = 4;
   localparam int DIGITS_DEF = 4;

   typedef logic [NIBBLE_W-1:0] bcd_nibble_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      PENDING = 2'd2,
      COMMIT  = 2'd3
   } state_e;

   function automatic int unsigned pow10(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam int unsigned DIGIT_MAX = pow10(DIGITS_DEF) - 1;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: every BCD nibble >= 5 gets +3, then the
// concatenation {bcd, bin} is shifted left by one bit.
//   bcd_i / bcd_o : BCD accumulator, DIGITS+1 nibbles
//   bin_i / bin_o : remaining binary bits, MSB shifts into the accumulator
module bcd_dabble_step
   import display_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int DIGITS = 4
) (
   input  logic [NIBBLE_W*(DIGITS+1)-1:0] bcd_i,
   input  logic [IN_W-1:0]                bin_i,
   output logic [NIBBLE_W*(DIGITS+1)-1:0] bcd_o,
   output logic [IN_W-1:0]                bin_o
);

   localparam int ACC_W = NIBBLE_W*(DIGITS+1);

   logic [ACC_W-1:0] adj;

   always_comb begin
      adj = bcd_i;
      for (int i = 0; i < DIGITS+1; i++) begin
         if (bcd_i[i*NIBBLE_W +: NIBBLE_W] >= bcd_nibble_t'(5))
            adj[i*NIBBLE_W +: NIBBLE_W] = bcd_i[i*NIBBLE_W +: NIBBLE_W] + bcd_nibble_t'(3);
      end
   end

   assign {bcd_o, bin_o} = {adj, bin_i} << 1;

endmodule

// File: rtl/frame_sync_digit_loader.sv
// Accepts a binary result over valid/ready, converts it to BCD with a
// sequential double-dabble (IN_W cycles) and commits the digits to the
// picture generator's `numbers` bus only at the start of vertical sync.
//
// Ports:
//   clk          : pixel/system clock (same as VGA_sync)
//   rst_n        : asynchronous active-low reset
//   in_valid     : calculator presents in_value
//   in_ready     : loader can accept (IDLE only)
//   in_value     : unsigned binary result, IN_W bits
//   vsync_in     : vga_v_sync, same clock domain
//   numbers      : BCD digits, nibble 0 = leftmost (most significant) digit
//   busy         : high in CONVERT, PENDING or COMMIT
//   commit_pulse : one-cycle strobe in the cycle `numbers` changes
//   ovf          : value was clamped to the display maximum
//
// Build option DIGIT_SATURATE_EN: inputs above 10^DIGITS-1 are clamped to
// 10^DIGITS-1 and ovf reports it from commit to commit. Without it values
// are shown modulo 10^DIGITS and ovf is tied low.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | in_ready high, waiting for in_valid
// CONVERT | IN_W double-dabble iterations
// PENDING | digits ready, waiting for the start of vertical sync
// COMMIT  | numbers just loaded, commit_pulse high
module frame_sync_digit_loader
   import display_pkg::*;
#(
   parameter int IN_W             = 16,
   parameter int DIGITS           = 4,
   parameter int VSYNC_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       in_value,
   input  logic                  vsync_in,
   output logic [4*DIGITS-1:0]   numbers,
   output logic                  busy,
   output logic                  commit_pulse,
   output logic                  ovf
);

   localparam int              ACC_W       = NIBBLE_W*(DIGITS+1);
   localparam int              CNT_W       = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(IN_W-1);
   localparam logic            VS_INACTIVE = (VSYNC_ACTIVE_LOW != 0);

   state_e              state_q, state_d;
   logic [ACC_W-1:0]    bcd_q, bcd_d, bcd_step;
   logic [IN_W-1:0]     bin_q, bin_d, bin_step;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                vsync_q;
   logic                vsync_edge;
   logic [4*DIGITS-1:0] numbers_q, numbers_d, digits_ordered;
   logic [IN_W-1:0]     load_value;
   logic                accept;
   logic                commit_go;

   assign accept     = (state_q == IDLE) && in_valid;
   // Start of vsync: previous sample inactive, current sample active.
   assign vsync_edge = (vsync_q == VS_INACTIVE) && (vsync_in != VS_INACTIVE);
   assign commit_go  = (state_q == PENDING) && vsync_edge;

`ifdef DIGIT_SATURATE_EN
   // Assumes 10^DIGITS-1 is representable in IN_W bits.
   localparam logic [IN_W-1:0] SAT_VAL = IN_W'(pow10(DIGITS) - 1);

   logic sat_hit;
   logic ovf_pending_q, ovf_pending_d;
   logic ovf_q, ovf_d;

   assign sat_hit    = (in_value > SAT_VAL);
   assign load_value = sat_hit ? SAT_VAL : in_value;

   always_comb begin
      ovf_pending_d = ovf_pending_q;
      ovf_d         = ovf_q;
      if (accept)    ovf_pending_d = sat_hit;
      if (commit_go) ovf_d         = ovf_pending_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_pending_q <= 1'b0;
         ovf_q         <= 1'b0;
      end else begin
         ovf_pending_q <= ovf_pending_d;
         ovf_q         <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign load_value = in_value;
   assign ovf        = 1'b0;
`endif

   bcd_dabble_step #(
      .IN_W   (IN_W),
      .DIGITS (DIGITS)
   ) u_step (
      .bcd_i (bcd_q),
      .bin_i (bin_q),
      .bcd_o (bcd_step),
      .bin_o (bin_step)
   );

   // Accumulator keeps units in the low nibble; the display wants the most
   // significant kept digit in nibble 0. The extra top nibble is dropped,
   // which gives value mod 10^DIGITS.
   always_comb begin
      digits_ordered = '0;
      for (int i = 0; i < DIGITS; i++)
         digits_ordered[i*NIBBLE_W +: NIBBLE_W] = bcd_q[(DIGITS-1-i)*NIBBLE_W +: NIBBLE_W];
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)            state_d = CONVERT;
         CONVERT: if (cnt_q == CNT_LAST)   state_d = PENDING;
         PENDING: if (vsync_edge)          state_d = COMMIT;
         COMMIT:                           state_d = IDLE;
         default:                          state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready     = 1'b0;
      busy         = 1'b1;
      commit_pulse = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         COMMIT:  commit_pulse = 1'b1;
         default: ;
      endcase
   end

   // Datapath next state
   always_comb begin
      bcd_d     = bcd_q;
      bin_d     = bin_q;
      cnt_d     = cnt_q;
      numbers_d = numbers_q;
      if (accept) begin
         bin_d = load_value;
         bcd_d = '0;
         cnt_d = '0;
      end else if (state_q == CONVERT) begin
         bcd_d = bcd_step;
         bin_d = bin_step;
         cnt_d = cnt_q + 1'b1;
      end
      // numbers changes on entry to COMMIT so it moves together with commit_pulse.
      if (commit_go) numbers_d = digits_ordered;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q     <= '0;
         bin_q     <= '0;
         cnt_q     <= '0;
         vsync_q   <= VS_INACTIVE;
         numbers_q <= '0;
      end else begin
         bcd_q     <= bcd_d;
         bin_q     <= bin_d;
         cnt_q     <= cnt_d;
         vsync_q   <= vsync_in;
         numbers_q <= numbers_d;
      end
   end

   assign numbers = numbers_q;

endmodule

// File: tb/tb_frame_sync_digit_loader.sv
`timescale 1ns/1ps
module tb_frame_sync_digit_loader;

   localparam int IN_W   = 16;
   localparam int DIGITS = 4;
   localparam int NW     = 4*DIGITS;
   localparam int MAXV   = 9999;
   localparam int MODV   = 10000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [IN_W-1:0] in_value;
   logic          vsync_in;
   logic [NW-1:0] numbers;
   logic          busy;
   logic          commit_pulse;
   logic          ovf;

   always #5 clk = ~clk;

   frame_sync_digit_loader #(
      .IN_W             (IN_W),
      .DIGITS           (DIGITS),
      .VSYNC_ACTIVE_LOW (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_value     (in_value),
      .vsync_in     (vsync_in),
      .numbers      (numbers),
      .busy         (busy),
      .commit_pulse (commit_pulse),
      .ovf          (ovf)
   );

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the display should show for a value, in decimal.
   function automatic logic [NW-1:0] to_display(input int unsigned v);
      int unsigned x;
      int unsigned div;
      logic [NW-1:0] r;
`ifdef DIGIT_SATURATE_EN
      x = (v > MAXV) ? MAXV : v;
`else
      x = v % MODV;
`endif
      r   = '0;
      div = MODV / 10;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'((x / div) % 10);
         div = div / 10;
      end
      return r;
   endfunction

   function automatic logic ovf_of(input int unsigned v);
`ifdef DIGIT_SATURATE_EN
      return v > MAXV;
`else
      return (v > MAXV) && 1'b0;
`endif
   endfunction

   typedef struct {
      int unsigned   cyc;
      logic [NW-1:0] num;
      logic          ov;
   } exp_t;

   exp_t          sb[$];
   exp_t          e;
   int unsigned   cyc_n;
   int            m_phase;      // 0 ready, 1 holding a value, 2 commit cycle
   int unsigned   m_t0;
   logic [NW-1:0] m_pend_num;
   logic          m_pend_ov;
   logic [NW-1:0] m_shown;
   logic          m_shown_ov;
   logic          m_ready;
   logic          m_vprev;
   logic          m_vedge;
   logic          exp_pulse;

   // Cycle-level behavioural model: a value accepted at clock n is shown from
   // the first vsync falling edge sampled at clock >= n+IN_W+1, and the
   // loader is ready again two clocks after that commit.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase    = 0;
         m_ready    = 1'b1;
         m_vprev    = 1'b1;
         m_shown    = '0;
         m_shown_ov = 1'b0;
         cyc_n      = 0;
         sb.delete();
      end else begin
         cyc_n++;
         m_vedge = m_vprev && !vsync_in;
         m_vprev = vsync_in;
         case (m_phase)
            0: if (in_valid) begin
               m_t0       = cyc_n;
               m_pend_num = to_display(32'(in_value));
               m_pend_ov  = ovf_of(32'(in_value));
               m_phase    = 1;
               m_ready    = 1'b0;
            end
            1: if (m_vedge && cyc_n >= m_t0 + IN_W + 1) begin
               sb.push_back('{cyc: cyc_n, num: m_pend_num, ov: m_pend_ov});
               m_shown    = m_pend_num;
               m_shown_ov = m_pend_ov;
               m_phase    = 2;
            end
            default: begin
               m_phase = 0;
               m_ready = 1'b1;
            end
         endcase
      end
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", in_ready, m_ready);
         check("busy", busy, m_phase != 0);
         check("numbers", numbers, m_shown);
         check("ovf", ovf, m_shown_ov);
         exp_pulse = (sb.size() > 0) && (sb[0].cyc == cyc_n);
         check("commit_pulse", commit_pulse, exp_pulse);
         if (exp_pulse) begin
            e = sb.pop_front();
            check("commit_numbers", numbers, e.num);
            check("commit_ovf", ovf, e.ov);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic vs_pulse(input int w);
      vsync_in = 1'b0;
      tick(w);
      vsync_in = 1'b1;
   endtask

   task automatic send(input logic [IN_W-1:0] v, input bit hold_after);
      bit got;
      got      = 1'b0;
      in_valid = 1'b1;
      in_value = v;
      for (int k = 0; k < 3000 && !got; k++) begin
         @(negedge clk);
         got = in_ready;
         tick(1);
      end
      check("accept", got, 1'b1);
      if (!hold_after) in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   bit done;

   initial begin
      in_valid = 1'b0;
      in_value = '0;
      vsync_in = 1'b1;
      rst_n    = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst_numbers", numbers, 16'h0000);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_commit", commit_pulse, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // Basic load, commit 100 cycles later
      send(16'd1234, 1'b0);
      tick(100);
      check("basic_hold", numbers, 16'h0000);
      vs_pulse(4);
      tick(5);
      check("basic_1234", numbers, 16'h4321);

      // vsync edge during CONVERT is not remembered
      send(16'd5678, 1'b0);
      tick(4);
      vs_pulse(2);
      tick(40);
      check("convert_edge_ignored", numbers, 16'h4321);
      vs_pulse(2);
      tick(5);
      check("next_frame_5678", numbers, 16'h8765);

      // Back-to-back with in_valid held
      fork
         begin
            send(16'd7, 1'b1);
            send(16'd42, 1'b0);
         end
         begin
            tick(30);
            vs_pulse(3);
            check("b2b_first_7", numbers, 16'h7000);
            tick(30);
            vs_pulse(3);
            tick(10);
         end
      join
      check("b2b_second_42", numbers, 16'h2400);

      // Overflow handling
      send(16'd12345, 1'b0);
      tick(20);
      vs_pulse(2);
      tick(3);
`ifdef DIGIT_SATURATE_EN
      check("ovf_numbers", numbers, 16'h9999);
      check("ovf_flag", ovf, 1'b1);
`else
      check("ovf_numbers", numbers, 16'h5432);
      check("ovf_flag", ovf, 1'b0);
`endif
      send(16'd5, 1'b0);
      tick(20);
      vs_pulse(2);
      tick(3);
      check("after_ovf_numbers", numbers, 16'h5000);
      check("after_ovf_flag", ovf, 1'b0);

      // Asynchronous reset in the middle of CONVERT
      send(16'd4321, 1'b0);
      tick(5);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_numbers", numbers, 16'h0000);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_commit", commit_pulse, 1'b0);
      check("midrst_ovf", ovf, 1'b0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // Randomized traffic against free-running vsync
      done = 1'b0;
      fork
         begin
            for (int n = 0; n < 30; n++) begin
               logic [IN_W-1:0] v;
               int gap;
               case ($urandom_range(0, 3))
                  0:       v = IN_W'($urandom_range(0, 9));
                  1:       v = IN_W'($urandom_range(0, 9999));
                  2:       v = IN_W'($urandom_range(10000, 65535));
                  default: v = IN_W'($urandom);
               endcase
               gap = $urandom_range(0, 5);
               send(v, gap == 0);
               if (gap != 0) tick(gap);
            end
            in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               tick($urandom_range(10, 45));
               vs_pulse($urandom_range(1, 4));
            end
         end
      join
      repeat (2) begin
         tick(25);
         vs_pulse(2);
      end
      tick(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
